// File: rtl/btn_event.sv
// btn_event: debounced push-button event generator.
//
// The raw active-low button is synchronised into the clk domain and sampled
// once per prescaler tick. A level change is accepted only after DB_TICKS
// consecutive disagreeing ticks. Once the press is accepted, the block emits a
// single long-press pulse after HOLD_TICKS ticks and then an auto-repeat pulse
// every RPT_TICKS ticks until the release is accepted.
//
// Ports
//   clk        in   system clock (single clock domain)
//   rst_n      in   asynchronous active-low reset
//   i_sw       in   raw push-button, active-low, asynchronous, may bounce
//   o_level    out  debounced button state, 1 = pressed
//   o_press    out  one-clk pulse when a press is accepted
//   o_release  out  one-clk pulse when a release is accepted
//   o_long     out  one-clk pulse, once per press, when the hold reaches HOLD_TICKS
//   o_repeat   out  one-clk auto-repeat pulse while held past HOLD_TICKS
module btn_event #(
  parameter int TICK_DIV   = 50000,
  parameter int DB_TICKS   = 20,
  parameter int HOLD_TICKS = 1000,
  parameter int RPT_TICKS  = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW   = (DB_TICKS > 1) ? $clog2(DB_TICKS + 1) : 1;
  localparam int HMAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    RPT
  } state_t;

  // Synchroniser resets to the released level (i_sw = 1).
  logic [1:0]    sync_q;
  logic          sw_s;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  logic [DW-1:0] db_q, db_d;
  logic          level_q, level_d;
  logic          rise, fall;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;

  logic          press_q, release_q, long_q, rpt_q;
  logic          long_d, rpt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], i_sw};
    end
  end

  assign sw_s = ~sync_q[1];

  // Prescaler
  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_comb begin
    pre_d = pre_q + 1'b1;
    if (tick) begin
      pre_d = '0;
    end
  end

  // Debounce: the counter only ever reaches DB_TICKS-1; the tick that would
  // bring it to DB_TICKS toggles the level and clears it instead.
  always_comb begin
    db_d    = db_q;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (tick) begin
      if (sw_s != level_q) begin
        if (db_q == DW'(DB_TICKS - 1)) begin
          db_d    = '0;
          level_d = ~level_q;
          rise    = sw_s;
          fall    = ~sw_s;
        end else begin
          db_d = db_q + 1'b1;
        end
      end else begin
        db_d = '0;
      end
    end
  end

  // Hold / repeat FSM. An accepted release is checked before the expiry
  // tests so that a release on the expiry tick suppresses o_long/o_repeat.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HELD;
          hold_d  = '0;
        end
      end
      HELD: begin
        if (fall) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (tick) begin
          if (hold_q == HW'(HOLD_TICKS - 1)) begin
            long_d  = 1'b1;
            rpt_d   = 1'b1;
            state_d = RPT;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      RPT: begin
        if (fall) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (tick) begin
          if (hold_q == HW'(RPT_TICKS - 1)) begin
            rpt_d  = 1'b1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      db_q      <= '0;
      level_q   <= 1'b0;
      state_q   <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      db_q      <= db_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= rise;
      release_q <= fall;
      long_q    <= long_d;
      rpt_q     <= rpt_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = rpt_q;

endmodule

// File: tb/tb_btn_event.sv
module tb_btn_event;

  localparam int TD   = 4;
  localparam int DB   = 3;
  localparam int HOLD = 5;
  localparam int RPTN = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic i_sw;
  logic o_level, o_press, o_release, o_long, o_repeat;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // observed pulse tallies (reset per scenario)
  int n_press, n_rel, n_long, n_rep;
  int press_cyc, long_cyc, rel_cyc;

  // reference model state
  logic m_s1, m_s2, m_lvl;
  int   m_pre, m_db, m_since;
  logic e_press, e_rel, e_long, e_rep;

  btn_event #(
    .TICK_DIV  (TD),
    .DB_TICKS  (DB),
    .HOLD_TICKS(HOLD),
    .RPT_TICKS (RPTN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sw     (i_sw),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long),
    .o_repeat (o_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_tally();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
    press_cyc = -1; long_cyc = -1; rel_cyc = -1;
  endtask

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0;
    m_pre = 0; m_db = 0; m_since = 0;
    e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
  endtask

  // One clock edge of the behavioural model. Long/repeat are derived from
  // the number of ticks elapsed since the accepted press.
  task automatic model_step(input logic sw);
    logic sws, tk, was_pressed;
    sws  = ~m_s2;
    m_s2 = m_s1;
    m_s1 = sw;
    tk    = (m_pre == TD - 1);
    m_pre = (m_pre + 1) % TD;
    e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
    if (tk) begin
      was_pressed = m_lvl;
      if (sws != m_lvl) begin
        m_db++;
        if (m_db == DB) begin
          m_db  = 0;
          m_lvl = sws;
          e_press = sws;
          e_rel   = !sws;
        end
      end else begin
        m_db = 0;
      end
      if (e_press) begin
        m_since = 0;
      end else if (was_pressed && !e_rel) begin
        m_since++;
        if (m_since == HOLD) begin
          e_long = 1; e_rep = 1;
        end else if (m_since > HOLD && ((m_since - HOLD) % RPTN) == 0) begin
          e_rep = 1;
        end
      end
    end
  endtask

  task automatic cycle(input logic sw);
    i_sw = sw;
    @(posedge clk);
    model_step(sw);
    #1;
    cyc++;
    chk("level",   o_level,   m_lvl);
    chk("press",   o_press,   e_press);
    chk("release", o_release, e_rel);
    chk("long",    o_long,    e_long);
    chk("repeat",  o_repeat,  e_rep);
    if (o_press)   begin n_press++; press_cyc = cyc; end
    if (o_release) begin n_rel++;   rel_cyc   = cyc; end
    if (o_long)    begin n_long++;  long_cyc  = cyc; end
    if (o_repeat)  n_rep++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"},   o_level,   1'b0);
    chk({tag, "_press"},   o_press,   1'b0);
    chk({tag, "_release"}, o_release, 1'b0);
    chk({tag, "_long"},    o_long,    1'b0);
    chk({tag, "_repeat"},  o_repeat,  1'b0);
  endtask

  // Called just after a posedge; asserts reset away from the edge.
  task automatic do_reset(input int ncyc, input logic sw);
    rst_n = 1'b0;
    i_sw  = sw;
    #1;
    chk_zero("rst_now");
    model_reset();
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    rst_n = 1'b1;
  endtask

  // Hold i_sw low until o_press, bounded; returns latency in clk.
  task automatic wait_press(input string tag, output int lat);
    int start;
    start = cyc;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0);
      if (o_press) begin
        lat = cyc - start;
        break;
      end
    end
    chk({tag, "_latency_ok"}, (lat >= 10 && lat <= 18), 1'b1);
  endtask

  initial begin
    int lat, rep_before, len;
    logic sw;
    rst_n = 1'b0;
    i_sw  = 1'b1;
    #2;
    chk_zero("por");
    do_reset(2, 1'b1);

    // idle settle
    repeat (8) cycle(1'b1);

    // clean press followed by long hold (60 ticks)
    clear_tally();
    wait_press("clean", lat);
    repeat (60 * TD - lat) cycle(1'b0);
    chk_int("long_hold_presses", n_press, 1);
    chk_int("long_hold_longs", n_long, 1);
    chk_int("long_after_press_clk", long_cyc - press_cyc, HOLD * TD);
    chk("long_hold_level", o_level, 1'b1);

    // release
    rep_before = n_rep;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b1);
      if (o_release) begin
        lat = k + 1;
        break;
      end
    end
    chk("release_latency_ok", (lat >= 10 && lat <= 18), 1'b1);
    repeat (40) cycle(1'b1);
    chk_int("release_count", n_rel, 1);
    chk_int("long_total", n_long, 1);
    chk("release_level", o_level, 1'b0);

    // bounce rejection
    clear_tally();
    repeat (5) begin
      repeat (8) cycle(1'b0);
      repeat (4) cycle(1'b1);
    end
    repeat (40) cycle(1'b1);
    chk_int("bounce_pulses", n_press + n_rel + n_long + n_rep, 0);
    chk("bounce_level", o_level, 1'b0);

    // release accepted on the hold-expiry tick
    clear_tally();
    wait_press("coll", lat);
    repeat (2 * TD) cycle(1'b0);
    repeat (40) cycle(1'b1);
    chk_int("coll_release", n_rel, 1);
    chk_int("coll_long", n_long, 0);
    chk_int("coll_repeat", n_rep, 0);
    chk_int("coll_release_clk", rel_cyc - press_cyc, HOLD * TD);

    // reset while auto-repeating
    repeat (10) cycle(1'b1);
    clear_tally();
    wait_press("prerst", lat);
    repeat (30) cycle(1'b0);
    chk("prerst_level", o_level, 1'b1);
    do_reset(3, 1'b0);
    clear_tally();
    wait_press("postrst", lat);
    chk_int("postrst_release", n_rel, 0);
    repeat (10) cycle(1'b0);
    repeat (30) cycle(1'b1);

    // randomized segments checked against the model
    clear_tally();
    for (int s = 0; s < 120; s++) begin
      sw  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(40, 160))
                                        : int'($urandom_range(1, 20));
      repeat (len) cycle(sw);
    end
    repeat (60) cycle(1'b1);
    chk_int("rand_alternate", n_press, n_rel);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
